fp32_multiplier: RTL and testbench

//  Multi-cycle IEEE-754 binary32 multiplier used as an FPU datapath slice. Captures op1/op2 on a

---
 rtl/fp32_pkg.sv | 15 +
 rtl/fp32_round_pack.sv | 42 ++++
 rtl/fp32_multiplier.sv | 123 ++++++++++++
 tb/tb_fp32_multiplier.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared types and constants for the multi-cycle binary32 multiplier.
package fp32_pkg;

  typedef struct packed {
    logic        sgn;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  typedef enum logic [1:0] {IDLE, MULT, NORM, PACK} mul_state_t;

endpackage

// File: rtl/fp32_round_pack.sv
// Rounds a normalized significand and packs it into binary32, saturating to infinity or flushing to zero.
// Rounding is round-to-nearest-even when FP_MUL_RNE_EN is defined, truncation otherwise.
module fp32_round_pack
  import fp32_pkg::*;
(
  input  logic        sign,
  input  logic [9:0]  exp,
  input  logic [22:0] frac,
  input  logic        guard,
  input  logic        sticky,
  output logic [31:0] packed_word,
  output logic        overflow
);

  logic               inc;
  logic [23:0]        frac_rnd;
  logic signed [9:0]  exp_rnd;

`ifdef FP_MUL_RNE_EN
  assign inc = guard & (sticky | frac[0]);
`else
  logic rnd_unused;
  assign rnd_unused = guard | sticky;
  assign inc        = 1'b0;
`endif

  // a carry out of the fraction means the significand became 2.0, so bump the exponent
  assign frac_rnd = {1'b0, frac} + 24'(inc);
  assign exp_rnd  = $signed(exp) + $signed({9'b0, frac_rnd[23]});

  always_comb begin
    packed_word = {sign, 31'h0};
    overflow    = 1'b0;
    if (exp_rnd > 10'sd254) begin
      packed_word = {sign, 8'hFF, 23'h0};
      overflow    = 1'b1;
    end else if (exp_rnd > 10'sd0) begin
      packed_word = {sign, exp_rnd[7:0], frac_rnd[22:0]};
    end
  end

endmodule

// File: rtl/fp32_multiplier.sv
// Multi-cycle binary32 multiplier: IDLE -> MULT -> NORM -> PACK, one-cycle mul_done with held result.
// Optional build macro FP_MUL_RNE_EN selects round-to-nearest-even instead of truncation.
//
// state | meaning
// IDLE  | waiting for mul_start; operands latched on acceptance
// MULT  | sign, biased exponent sum and 48-bit significand product formed
// NORM  | product normalized to 23-bit fraction plus guard/sticky
// PACK  | rounded result and overflow registered, mul_done pulsed
module fp32_multiplier
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        mul_start,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        mul_done,
  output logic        mul_overflow,
  output logic [31:0] mul_result
);

  mul_state_t  state, state_nxt;
  fp32_t       op1_q, op2_q;
  logic        sign_q, zero_q, inf_q;
  logic [9:0]  exp_q;
  logic [47:0] prod_q;
  logic [22:0] frac_q;
  logic        guard_q, sticky_q;
  logic [31:0] rp_word;
  logic        rp_overflow;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mul_start) state_nxt = MULT;
      MULT:    state_nxt = NORM;
      NORM:    state_nxt = PACK;
      PACK:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      op1_q    <= '0;
      op2_q    <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      inf_q    <= 1'b0;
      exp_q    <= '0;
      prod_q   <= '0;
      frac_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (mul_start) begin
          op1_q <= fp32_t'(op1);
          op2_q <= fp32_t'(op2);
        end
        MULT: begin
          sign_q <= op1_q.sgn ^ op2_q.sgn;
          zero_q <= (op1_q.exp == 8'h00) || (op2_q.exp == 8'h00);
          inf_q  <= (op1_q.exp == 8'(EXP_MAX)) || (op2_q.exp == 8'(EXP_MAX));
          exp_q  <= {2'b00, op1_q.exp} + {2'b00, op2_q.exp} - 10'(EXP_BIAS);
          prod_q <= {24'h0, 1'b1, op1_q.frac} * {24'h0, 1'b1, op2_q.frac};
        end
        NORM: begin
          if (prod_q[47]) begin
            frac_q   <= prod_q[46:24];
            guard_q  <= prod_q[23];
            sticky_q <= |prod_q[22:0];
            exp_q    <= exp_q + 10'd1;
          end else begin
            frac_q   <= prod_q[45:23];
            guard_q  <= prod_q[22];
            sticky_q <= |prod_q[21:0];
          end
        end
        default: ;
      endcase
    end
  end

  fp32_round_pack u_round_pack (
    .sign        (sign_q),
    .exp         (exp_q),
    .frac        (frac_q),
    .guard       (guard_q),
    .sticky      (sticky_q),
    .packed_word (rp_word),
    .overflow    (rp_overflow)
  );

  // Inf/NaN operands win over zero operands so inf*0 reports overflow rather than a silent zero
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mul_done     <= 1'b0;
      mul_overflow <= 1'b0;
      mul_result   <= 32'h0;
    end else begin
      mul_done <= (state == PACK);
      if (state == PACK) begin
        if (inf_q) begin
          mul_result   <= {sign_q, 8'hFF, 23'h0};
          mul_overflow <= 1'b1;
        end else if (zero_q) begin
          mul_result   <= {sign_q, 31'h0};
          mul_overflow <= 1'b0;
        end else begin
          mul_result   <= rp_word;
          mul_overflow <= rp_overflow;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp32_multiplier.sv
// Directed self-checking bench for fp32_multiplier.
module tb_fp32_multiplier;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        mul_start = 1'b0;
  logic [31:0] op1 = 32'h0;
  logic [31:0] op2 = 32'h0;
  logic        mul_done;
  logic        mul_overflow;
  logic [31:0] mul_result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp32_multiplier dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .mul_start    (mul_start),
    .op1          (op1),
    .op2          (op2),
    .mul_done     (mul_done),
    .mul_overflow (mul_overflow),
    .mul_result   (mul_result)
  );

  // drives one operation from IDLE; lat = negedges after the accepting edge until mul_done (99 on timeout)
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic ovf, output int lat);
    @(negedge clk);
    op1 = a; op2 = b; mul_start = 1'b1;
    @(posedge clk);
    #1 mul_start = 1'b0;
    lat = 99;
    res = 32'hx;
    ovf = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mul_done) begin
        lat = k; res = mul_result; ovf = mul_overflow;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] r; logic o; int l;
    #1;
    total++;
    if (mul_done !== 1'b0 || mul_overflow !== 1'b0 || mul_result !== 32'h0) begin
      bad++; $display("FAIL reset_state: done=%b ovf=%b res=%h want 0/0/00000000", mul_done, mul_overflow, mul_result);
    end
    @(negedge clk); n_rst = 1'b1;
    run_op(32'h3FA00000, 32'h3FC00000, r, o, l);
    // start another op and pull reset while it is in flight
    @(negedge clk);
    op1 = 32'h40000000; op2 = 32'h40400000; mul_start = 1'b1;
    @(posedge clk); #1 mul_start = 1'b0;
    @(negedge clk); @(negedge clk);
    n_rst = 1'b0;
    #1;
    total++;
    if (mul_done !== 1'b0 || mul_overflow !== 1'b0 || mul_result !== 32'h0) begin
      bad++; $display("FAIL reset_midop: done=%b ovf=%b res=%h want 0/0/00000000", mul_done, mul_overflow, mul_result);
    end
    @(negedge clk); n_rst = 1'b1;
    l = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mul_done) l++;
    end
    total++;
    if (l !== 0) begin
      bad++; $display("FAIL reset_no_done: pulses=%0d want 0", l);
    end
  endtask

  task automatic test_basic();
    logic [31:0] r; logic o; int l;
    run_op(32'h3FA00000, 32'h3FC00000, r, o, l);
    total++;
    if (l !== 4) begin
      bad++; $display("FAIL basic_latency: got=%0d want 4", l);
    end
    total++;
    if (r !== 32'h3FF00000 || o !== 1'b0) begin
      bad++; $display("FAIL basic_result: res=%h ovf=%b want 3FF00000/0", r, o);
    end
    @(negedge clk);
    total++;
    if (mul_done !== 1'b0 || mul_result !== 32'h3FF00000) begin
      bad++; $display("FAIL basic_hold: done=%b res=%h want 0/3FF00000", mul_done, mul_result);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] va [8] = '{32'h40000000, 32'h3F800000, 32'hC0400000, 32'hC07FFFFF,
                            32'h7F000000, 32'h00000000, 32'h00800000, 32'h7F800000};
    logic [31:0] vb [8] = '{32'h40400000, 32'hC0C00000, 32'hC0800000, 32'hC0BFFFFF,
                            32'h40000000, 32'hC0400000, 32'h00800000, 32'hBF800000};
    logic [31:0] ve [8] = '{32'h40C00000, 32'hC0C00000, 32'h41400000, 32'h41BFFFFE,
                            32'h7F800000, 32'h80000000, 32'h00000000, 32'hFF800000};
    logic        vo [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] r; logic o; int l;
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], r, o, l);
      total++;
      if (l !== 4 || r !== ve[i] || o !== vo[i]) begin
        bad++;
        $display("FAIL vector_%0d: %h*%h lat=%0d res=%h ovf=%b want lat=4 res=%h ovf=%b",
                 i, va[i], vb[i], l, r, o, ve[i], vo[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int errs = 0;
    @(negedge clk);
    op1 = 32'hC0400000; op2 = 32'hC0800000; mul_start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (mul_done !== ((k % 4) == 0)) errs++;
      if (mul_done) begin
        pulses++;
        if (mul_result !== 32'h41400000 || mul_overflow !== 1'b0) errs++;
      end
    end
    mul_start = 1'b0;
    total++;
    if (pulses !== 4 || errs !== 0) begin
      bad++; $display("FAIL back_to_back: pulses=%0d errs=%0d want 4/0", pulses, errs);
    end
    // drain the operation accepted at the last sampled edge
    for (int k = 0; k < 6; k++) @(negedge clk);
  endtask

  task automatic test_busy_start();
    int pulses = 0;
    logic [31:0] r = 32'h0;
    @(negedge clk);
    op1 = 32'h40000000; op2 = 32'h40400000; mul_start = 1'b1;
    @(posedge clk); #1 mul_start = 1'b0;
    @(negedge clk);
    op1 = 32'h3F800000; op2 = 32'hC0C00000; mul_start = 1'b1;
    @(negedge clk); mul_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mul_done) begin pulses++; r = mul_result; end
    end
    total++;
    if (pulses !== 1 || r !== 32'h40C00000) begin
      bad++; $display("FAIL busy_start: pulses=%0d res=%h want 1/40C00000", pulses, r);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_busy_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
